// File: rtl/ks_adder_pipe.sv
// Pipelined Kogge-Stone adder/subtractor with valid/ready flow control.
// Define KS_OVF_EN to add the signed-overflow output Ovf.
module ks_adder_pipe #(
    parameter int WIDTH     = 16,
    parameter int REG_EVERY = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    input  logic             Sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] S,
    output logic             Cout
`ifdef KS_OVF_EN
   ,output logic             Ovf
`endif
);

    localparam int NL = $clog2(WIDTH);

    function automatic logic [WIDTH-1:0] ks_g(
        input logic [WIDTH-1:0] g,
        input logic [WIDTH-1:0] p,
        input int               span
    );
        logic [WIDTH-1:0] r;
        r = g;
        for (int i = span; i < WIDTH; i++) begin
            r[i] = g[i] | (p[i] & g[i-span]);
        end
        return r;
    endfunction

    function automatic logic [WIDTH-1:0] ks_p(
        input logic [WIDTH-1:0] p,
        input int               span
    );
        logic [WIDTH-1:0] r;
        r = p;
        for (int i = span; i < WIDTH; i++) begin
            r[i] = p[i] & p[i-span];
        end
        return r;
    endfunction

    logic adv;
    logic out_valid_q;

    assign adv      = !out_valid_q || out_ready;
    assign in_ready = adv;

    logic [WIDTH-1:0] b_d;
    logic             c0_d;
    logic [WIDTH-1:0] g_p_q;
    logic [WIDTH-1:0] p_p_q;
    logic             c0_p_q;
    logic             v_p_q;

    assign b_d  = Sub ? ~B : B;
    assign c0_d = Sub ? ~Cin : Cin;

    always_ff @(posedge clk) begin
        if (rst) begin
            v_p_q <= 1'b0;
        end else if (adv) begin
            v_p_q <= in_valid;
        end
    end

    always_ff @(posedge clk) begin
        if (adv) begin
            g_p_q  <= A & b_d;
            p_p_q  <= A ^ b_d;
            c0_p_q <= c0_d;
        end
    end

    // Per-level prefix signals; side carries the raw propagate and c0.
    logic [WIDTH-1:0] g_s  [NL+1];
    logic [WIDTH-1:0] p_s  [NL];
    logic [WIDTH:0]   sd_s [NL+1];
    logic             v_s  [NL+1];

    // Carry-in enters as a generate below bit 0.
    assign g_s[0]  = {g_p_q[WIDTH-1:1], g_p_q[0] | (p_p_q[0] & c0_p_q)};
    assign p_s[0]  = p_p_q;
    assign sd_s[0] = {p_p_q, c0_p_q};
    assign v_s[0]  = v_p_q;

    for (genvar l = 0; l < NL; l++) begin : g_lvl
        localparam int SPAN = 1 << l;
        localparam bit REG  = (((l + 1) % REG_EVERY) == 0) || (l == NL - 1);

        logic [WIDTH-1:0] g_d;
        assign g_d = ks_g(g_s[l], p_s[l], SPAN);

        if (REG) begin : g_reg
            logic [WIDTH-1:0] g_q;
            logic [WIDTH:0]   sd_q;
            logic             v_q;

            always_ff @(posedge clk) begin
                if (rst) begin
                    v_q <= 1'b0;
                end else if (adv) begin
                    v_q <= v_s[l];
                end
            end

            always_ff @(posedge clk) begin
                if (adv) begin
                    g_q  <= g_d;
                    sd_q <= sd_s[l];
                end
            end

            assign g_s[l+1]  = g_q;
            assign sd_s[l+1] = sd_q;
            assign v_s[l+1]  = v_q;
        end else begin : g_thru
            assign g_s[l+1]  = g_d;
            assign sd_s[l+1] = sd_s[l];
            assign v_s[l+1]  = v_s[l];
        end

        // The last level only needs group generates.
        if (l < NL - 1) begin : g_pp
            logic [WIDTH-1:0] p_d;
            assign p_d = ks_p(p_s[l], SPAN);

            if (REG) begin : g_reg
                logic [WIDTH-1:0] p_q;
                always_ff @(posedge clk) begin
                    if (adv) begin
                        p_q <= p_d;
                    end
                end
                assign p_s[l+1] = p_q;
            end else begin : g_thru
                assign p_s[l+1] = p_d;
            end
        end
    end

    logic [WIDTH-1:0] s_d;
    logic [WIDTH-1:0] s_q;
    logic             co_q;

    assign s_d = sd_s[NL][WIDTH:1] ^ {g_s[NL][WIDTH-2:0], sd_s[NL][0]};

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            s_q         <= '0;
            co_q        <= 1'b0;
        end else if (adv) begin
            out_valid_q <= v_s[NL];
            if (v_s[NL]) begin
                s_q  <= s_d;
                co_q <= g_s[NL][WIDTH-1];
            end
        end
    end

`ifdef KS_OVF_EN
    // Signed overflow equals carry into the MSB xor carry out of it.
    logic ovf_q;
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_q <= 1'b0;
        end else if (adv && v_s[NL]) begin
            ovf_q <= g_s[NL][WIDTH-1] ^ g_s[NL][WIDTH-2];
        end
    end
    assign Ovf = ovf_q;
`endif

    assign out_valid = out_valid_q;
    assign S         = s_q;
    assign Cout      = co_q;

endmodule

// File: tb/tb_ks_adder_pipe.sv
// Self-checking bench for ks_adder_pipe (WIDTH=16, REG_EVERY=1).
// Results are checked against an arithmetic model plus literal vectors.
module tb_ks_adder_pipe;

    localparam int W   = 16;
    localparam int LAT = 6;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         cin = 1'b0;
    logic         sub = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [W-1:0] s;
    logic         cout;
    logic         ovf;

    logic         lit_v = 1'b0;
    logic [W-1:0] lit_s = '0;
    logic         lit_c = 1'b0;
    logic         lit_o = 1'b0;

    always #5 clk = ~clk;

    ks_adder_pipe #(.WIDTH(W), .REG_EVERY(1)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (a),
        .B         (b),
        .Cin       (cin),
        .Sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .S         (s),
`ifdef KS_OVF_EN
        .Ovf       (ovf),
`endif
        .Cout      (cout)
    );

`ifndef KS_OVF_EN
    assign ovf = 1'b0;
`endif

    typedef struct {
        logic [W-1:0] s;
        logic         c;
        logic         o;
        int           t;
        logic         lv;
        logic [W-1:0] ls;
        logic         lc;
        logic         lo;
    } exp_t;

    exp_t q[$];
    int checks = 0;
    int errors = 0;
    int advcnt = 0;
    int pops   = 0;
    logic         stall_prev = 1'b0;
    logic [W-1:0] held_s;
    logic         held_c;
    logic         held_o;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, req);
        end
    endtask

    task automatic fail(input string nm);
        checks++;
        errors++;
        $display("FAIL %s", nm);
    endtask

    function automatic logic [W+1:0] model(
        input logic [W-1:0] ia,
        input logic [W-1:0] ib,
        input logic         ic,
        input logic         isub
    );
        logic [W-1:0] bp;
        logic         c0;
        logic [W:0]   sum;
        logic         o;
        bp  = isub ? ~ib : ib;
        c0  = isub ? ~ic : ic;
        sum = {1'b0, ia} + {1'b0, bp} + {{W{1'b0}}, c0};
        o   = (ia[W-1] == bp[W-1]) && (sum[W-1] != ia[W-1]);
        return {o, sum};
    endfunction

    always @(negedge clk) begin
        if (rst) begin
            q.delete();
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                chk("stall_hold_S", s, held_s);
                chk("stall_hold_Cout", cout, held_c);
                chk("stall_hold_Ovf", ovf, held_o);
            end
            if (out_valid && !out_ready) begin
                chk("stall_in_ready", in_ready, 0);
                held_s = s;
                held_c = cout;
                held_o = ovf;
                stall_prev = 1'b1;
            end else begin
                stall_prev = 1'b0;
            end
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    fail("unexpected_output_beat");
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    pops++;
                    chk("S", s, e.s);
                    chk("Cout", cout, e.c);
`ifdef KS_OVF_EN
                    chk("Ovf", ovf, e.o);
`endif
                    chk("latency", advcnt - e.t, LAT);
                    if (e.lv) begin
                        chk("lit_S", s, e.ls);
                        chk("lit_Cout", cout, e.lc);
`ifdef KS_OVF_EN
                        chk("lit_Ovf", ovf, e.lo);
`endif
                    end
                end
            end
            if (in_valid && in_ready) begin
                exp_t n;
                logic [W+1:0] m;
                m    = model(a, b, cin, sub);
                n.s  = m[W-1:0];
                n.c  = m[W];
                n.o  = m[W+1];
                n.t  = advcnt;
                n.lv = lit_v;
                n.ls = lit_s;
                n.lc = lit_c;
                n.lo = lit_o;
                q.push_back(n);
            end
            if (!out_valid || out_ready) advcnt++;
        end
    end

    // Called at posedge+1; leaves in_valid asserted for back-to-back beats.
    task automatic send(
        input logic [W-1:0] ia, input logic [W-1:0] ib,
        input logic ic, input logic isub,
        input logic lv, input logic [W-1:0] ls,
        input logic lc, input logic lo
    );
        bit ok;
        a = ia; b = ib; cin = ic; sub = isub;
        lit_v = lv; lit_s = ls; lit_c = lc; lit_o = lo;
        in_valid = 1'b1;
        ok = 1'b0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) fail("in_ready_timeout");
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        in_valid = 1'b0;
        lit_v = 1'b0;
    endtask

    task automatic drain();
        for (int k = 0; k < 100; k++) begin
            if (q.size() == 0) break;
            @(posedge clk);
            #1;
        end
        chk("drain_empty", q.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int p0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_S", s, 0);
        chk("rst_Cout", cout, 0);
`ifdef KS_OVF_EN
        chk("rst_Ovf", ovf, 0);
`endif
        chk("rst_in_ready", in_ready, 1);
        @(posedge clk);
        #1;

        send(16'hFFFF, 16'h0001, 0, 0, 1, 16'h0000, 1, 0);
        send(16'h1234, 16'h5678, 0, 0, 1, 16'h68AC, 0, 0);
        send(16'hAAAA, 16'h5555, 1, 0, 1, 16'h0000, 1, 0);
        idle();
        drain();

        send(16'h0005, 16'h0007, 0, 1, 1, 16'hFFFE, 0, 0);
        send(16'h8000, 16'h0001, 0, 1, 1, 16'h7FFF, 1, 1);
        send(16'h7FFF, 16'h0001, 0, 0, 1, 16'h8000, 0, 1);
        send(16'hFFFF, 16'hFFFF, 1, 0, 1, 16'hFFFF, 1, 0);
        idle();
        drain();

        p0 = pops;
        fork
            begin
                for (int i = 0; i < 10; i++) begin
                    send(W'($urandom), W'($urandom), 1'($urandom_range(0, 1)),
                         1'($urandom_range(0, 1)), 0, '0, 0, 0);
                end
                idle();
            end
            begin
                bit seen;
                seen = 1'b0;
                for (int k = 0; k < 100; k++) begin
                    @(negedge clk);
                    if (out_valid) begin
                        seen = 1'b1;
                        break;
                    end
                end
                if (!seen) fail("out_valid_timeout");
                @(posedge clk);
                #1 out_ready = 1'b0;
                repeat (3) @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        drain();
        chk("stream_count", pops - p0, 10);

        for (int i = 0; i < 4; i++) begin
            send(W'($urandom), W'($urandom), 0, 0, 0, '0, 0, 0);
        end
        idle();
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("midrst_out_valid", out_valid, 0);
        @(posedge clk);
        #1;
        p0 = pops;
        send(16'h0001, 16'h0002, 0, 0, 1, 16'h0003, 0, 0);
        send(16'h4000, 16'h4000, 0, 0, 1, 16'h8000, 0, 1);
        idle();
        drain();
        chk("post_rst_count", pops - p0, 2);
        repeat (3) @(posedge clk);
        #1;
        chk("final_out_valid", out_valid, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
